char_renderer: RTL and testbench

Pixel-side consumer of the character position window: runs 640x480@60 raster counters, latches the start/end window once per frame, and for every visible pixel inside the window issues a character-ROM read (`readEn`, `rowCnt`, `colCnt`). It then colours the returned glyph bit into `vgaRGB` with matching `hSync`/`vSync`. It sits between the window registers, the character ROM and the DAC pins.

---
 rtl/char_renderer_pkg.sv | 52 +++++
 rtl/char_renderer_sync_gen.sv | 58 +++++
 rtl/char_renderer.sv | 189 ++++++++++++++++++
 tb/tb_char_renderer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/char_renderer_pkg.sv
// Shared raster defaults, the window shadow type and the hit/offset helpers
// used by char_renderer and its raster generator.
package char_renderer_pkg;

    localparam int DEF_HDR  = 640;
    localparam int DEF_VDR  = 480;
    localparam int DEF_HAL  = 8;
    localparam int DEF_VAL  = 8;
    localparam int DEF_CHM  = 4;

    // 640x480@60 porches; totals come to 800 x 525.
    localparam int DEF_H_FP = 16;
    localparam int DEF_H_SW = 96;
    localparam int DEF_H_BP = 48;
    localparam int DEF_V_FP = 10;
    localparam int DEF_V_SW = 2;
    localparam int DEF_V_BP = 33;

    typedef struct packed {
        logic [8:0] ver_start;
        logic [8:0] ver_end;
        logic [9:0] hor_start;
        logic [9:0] hor_end;
    } window_t;

    // Inclusive band test; last < first means the band wraps past the edge.
    function automatic logic in_band(input logic [9:0] pos,
                                     input logic [9:0] first,
                                     input logic [9:0] last);
        logic hit;
        if (last >= first) begin
            hit = (pos >= first) && (pos <= last);
        end else begin
            hit = (pos >= first) || (pos <= last);
        end
        return hit;
    endfunction

    function automatic logic [9:0] wrap_offset(input logic [9:0] pos,
                                               input logic [9:0] first,
                                               input logic [9:0] span);
        logic [9:0] diff;
        diff = pos - first;
        if (pos < first) begin
            diff = diff + span;
        end else begin
            diff = diff;
        end
        return diff;
    endfunction

endpackage

// File: rtl/char_renderer_sync_gen.sv
// Raster generator for char_renderer: h/v counters, visible flag and raw
// active-low sync decode, all taken straight from the counter state.
module vga_sync_gen
    import char_renderer_pkg::*;
#(
    parameter int HDR  = DEF_HDR,
    parameter int VDR  = DEF_VDR,
    parameter int H_FP = DEF_H_FP,
    parameter int H_SW = DEF_H_SW,
    parameter int H_BP = DEF_H_BP,
    parameter int V_FP = DEF_V_FP,
    parameter int V_SW = DEF_V_SW,
    parameter int V_BP = DEF_V_BP
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] o_h,
    output logic [9:0] o_v,
    output logic       o_visible,
    output logic       o_hsync_n,
    output logic       o_vsync_n
);

    localparam logic [9:0] H_LAST   = 10'(HDR + H_FP + H_SW + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(VDR + V_FP + V_SW + V_BP - 1);
    localparam logic [9:0] HS_FIRST = 10'(HDR + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(HDR + H_FP + H_SW - 1);
    localparam logic [9:0] VS_FIRST = 10'(VDR + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(VDR + V_FP + V_SW - 1);

    logic [9:0] r_h;
    logic [9:0] r_v;

    // Free-running raster position; v steps once per h wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h <= 10'd0;
            r_v <= 10'd0;
        end else if (r_h == H_LAST) begin
            r_h <= 10'd0;
            if (r_v == V_LAST) begin
                r_v <= 10'd0;
            end else begin
                r_v <= r_v + 10'd1;
            end
        end else begin
            r_h <= r_h + 10'd1;
            r_v <= r_v;
        end
    end

    assign o_h       = r_h;
    assign o_v       = r_v;
    assign o_visible = (r_h < 10'(HDR)) && (r_v < 10'(VDR));
    assign o_hsync_n = ~((r_h >= HS_FIRST) && (r_h <= HS_LAST));
    assign o_vsync_n = ~((r_v >= VS_FIRST) && (r_v <= VS_LAST));

endmodule

// File: rtl/char_renderer.sv
// Character window renderer: latches the window once per frame, issues glyph
// ROM reads inside it and colours the result. CHAR_BORDER_EN adds a ~bgColor frame.
module char_renderer
    import char_renderer_pkg::*;
#(
    parameter int HDR  = DEF_HDR,
    parameter int VDR  = DEF_VDR,
    parameter int HAL  = DEF_HAL,
    parameter int VAL  = DEF_VAL,
    parameter int CHM  = DEF_CHM,
    parameter int H_FP = DEF_H_FP,
    parameter int H_SW = DEF_H_SW,
    parameter int H_BP = DEF_H_BP,
    parameter int V_FP = DEF_V_FP,
    parameter int V_SW = DEF_V_SW,
    parameter int V_BP = DEF_V_BP
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8:0]              posVerStart,
    input  logic [8:0]              posVerEnd,
    input  logic [9:0]              posHorStart,
    input  logic [9:0]              posHorEnd,
    input  logic [8:0]              fgColor,
    input  logic [8:0]              bgColor,
    input  logic                    charPixel,
    output logic                    readEn,
    output logic [$clog2(VAL)-1:0]  rowCnt,
    output logic [$clog2(HAL)-1:0]  colCnt,
    output logic [8:0]              vgaRGB,
    output logic                    hSync,
    output logic                    vSync
);

    localparam int CHM_SH  = $clog2(CHM);
    localparam int COL_W   = $clog2(HAL);
    localparam int ROW_W   = $clog2(VAL);
    localparam int GLYPH_W = HAL * CHM;
    localparam int GLYPH_H = VAL * CHM;

    localparam window_t WIN_RST = '{
        ver_start: 9'((VDR - GLYPH_H) / 2),
        ver_end:   9'((VDR - GLYPH_H) / 2 + GLYPH_H - 1),
        hor_start: 10'((HDR - GLYPH_W) / 2),
        hor_end:   10'((HDR - GLYPH_W) / 2 + GLYPH_W - 1)
    };

    logic [9:0]       w_h;
    logic [9:0]       w_v;
    logic             w_visible;
    logic             w_hsync_raw;
    logic             w_vsync_raw;
    window_t          r_win;
    logic             w_latch;
    logic             w_hhit;
    logic             w_vhit;
    logic             w_hit;
    logic [9:0]       w_dh;
    logic [9:0]       w_dv;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             r_s1_hsync;
    logic             r_s1_vsync;
    logic [8:0]       w_pix_rgb;
    logic             w_unused_ok;

    vga_sync_gen #(
        .HDR  (HDR),
        .VDR  (VDR),
        .H_FP (H_FP),
        .H_SW (H_SW),
        .H_BP (H_BP),
        .V_FP (V_FP),
        .V_SW (V_SW),
        .V_BP (V_BP)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .o_h       (w_h),
        .o_v       (w_v),
        .o_visible (w_visible),
        .o_hsync_n (w_hsync_raw),
        .o_vsync_n (w_vsync_raw)
    );

    // First blank line is the only point the window inputs are looked at.
    assign w_latch = (w_h == 10'd0) && (w_v == 10'(VDR));

    // Shadow window, refreshed once per frame so a frame is never torn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win <= WIN_RST;
        end else if (w_latch) begin
            r_win <= '{ver_start: posVerStart, ver_end: posVerEnd,
                       hor_start: posHorStart, hor_end: posHorEnd};
        end else begin
            r_win <= r_win;
        end
    end

    assign w_hhit = in_band(w_h, r_win.hor_start, r_win.hor_end);
    assign w_vhit = in_band(w_v, {1'b0, r_win.ver_start}, {1'b0, r_win.ver_end});
    assign w_hit  = w_visible && w_hhit && w_vhit;

    assign w_dh  = wrap_offset(w_h, r_win.hor_start, 10'(HDR));
    assign w_dv  = wrap_offset(w_v, {1'b0, r_win.ver_start}, 10'(VDR));
    assign w_col = w_dh[CHM_SH +: COL_W];
    assign w_row = w_dv[CHM_SH +: ROW_W];

    // Offset bits above the glyph index only matter to the border decode.
    assign w_unused_ok = &{1'b0, w_dh, w_dv};

    // S1: ROM read strobe and glyph address; the address holds outside a hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readEn     <= 1'b0;
            rowCnt     <= {ROW_W{1'b0}};
            colCnt     <= {COL_W{1'b0}};
            r_s1_hsync <= 1'b1;
            r_s1_vsync <= 1'b1;
        end else begin
            readEn     <= w_hit;
            r_s1_hsync <= w_hsync_raw;
            r_s1_vsync <= w_vsync_raw;
            if (w_hit) begin
                rowCnt <= w_row;
                colCnt <= w_col;
            end else begin
                rowCnt <= rowCnt;
                colCnt <= colCnt;
            end
        end
    end

`ifdef CHAR_BORDER_EN
    logic w_border;
    logic r_s1_border;

    assign w_border = (w_dh == 10'd0) || (w_dh == 10'(GLYPH_W - 1)) ||
                      (w_dv == 10'd0) || (w_dv == 10'(GLYPH_H - 1));

    // Border flag travels beside readEn so it meets the ROM data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_border <= 1'b0;
        end else begin
            r_s1_border <= w_hit && w_border;
        end
    end

    // Colour select with the border overriding the glyph bit.
    always_comb begin
        w_pix_rgb = 9'd0;
        if (readEn) begin
            if (r_s1_border) begin
                w_pix_rgb = ~bgColor;
            end else begin
                w_pix_rgb = charPixel ? fgColor : bgColor;
            end
        end else begin
            w_pix_rgb = 9'd0;
        end
    end
`else
    // Colour select: glyph inside the window, black everywhere else.
    always_comb begin
        w_pix_rgb = 9'd0;
        if (readEn) begin
            w_pix_rgb = charPixel ? fgColor : bgColor;
        end else begin
            w_pix_rgb = 9'd0;
        end
    end
`endif

    // S2: pixel colour with syncs delayed to stay aligned with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vgaRGB <= 9'd0;
            hSync  <= 1'b1;
            vSync  <= 1'b1;
        end else begin
            vgaRGB <= w_pix_rgb;
            hSync  <= r_s1_hsync;
            vSync  <= r_s1_vsync;
        end
    end

endmodule

// File: tb/tb_char_renderer.sv
// Scoreboard bench for char_renderer; vertical blanking is shortened
// (48 visible lines, 56 total) so two frames fit in a short run.
module tb_char_renderer;

    localparam logic [8:0] FG = 9'h1C3;
    localparam logic [8:0] BG = 9'h04A;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] posVerStart, posVerEnd, fgColor, bgColor;
    logic [9:0] posHorStart, posHorEnd;
    logic       charPixel, readEn, hSync, vSync;
    logic [2:0] rowCnt, colCnt;
    logic [8:0] vgaRGB;

    char_renderer #(.VDR(48), .V_FP(4), .V_SW(2), .V_BP(2)) dut (
        .clk(clk), .reset(reset),
        .posVerStart(posVerStart), .posVerEnd(posVerEnd),
        .posHorStart(posHorStart), .posHorEnd(posHorEnd),
        .fgColor(fgColor), .bgColor(bgColor), .charPixel(charPixel),
        .readEn(readEn), .rowCnt(rowCnt), .colCnt(colCnt),
        .vgaRGB(vgaRGB), .hSync(hSync), .vSync(vSync)
    );

    always #20 clk = ~clk;

    // Glyph ROM stand-in: a checkerboard of 1-pixel glyph cells.
    assign charPixel = colCnt[0] ^ rowCnt[0];

    typedef struct { int due; int kind; logic [9:0] val; } exp_t;
    typedef struct { int h; int v; int re; int col; int row; int rgb; int edge_; int hs; int vs; } vec_t;

    exp_t sb[$];
    vec_t vecs [0:29];
    int   cyc = 0;
    int   mh = 0;
    int   mv = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    // Reference raster position: 800 columns by 56 lines.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            mh <= 0;
            mv <= 0;
        end else if (mh == 799) begin
            mh <= 0;
            mv <= (mv == 55) ? 0 : mv + 1;
        end else begin
            mh <= mh + 1;
        end
    end

    function automatic string kname(input int k);
        case (k)
            0: return "readEn";
            1: return "colCnt";
            2: return "rowCnt";
            3: return "vgaRGB";
            4: return "hSync";
            5: return "vSync";
            default: return "unknown";
        endcase
    endfunction

    // Monitor: compare every expectation that falls due this cycle.
    always @(negedge clk) begin
        logic [9:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                case (sb[i].kind)
                    0: act = {9'd0, readEn};
                    1: act = {7'd0, colCnt};
                    2: act = {7'd0, rowCnt};
                    3: act = {1'b0, vgaRGB};
                    4: act = {9'd0, hSync};
                    5: act = {9'd0, vSync};
                    default: act = 10'h3FF;
                endcase
                n_vec = n_vec + 1;
                if (act !== sb[i].val) begin
                    n_miss = n_miss + 1;
                    $display("FAIL %s at cycle %0d: got %h, expected %h", kname(sb[i].kind), cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    function automatic logic [8:0] exp_rgb(input int code, input int edge_);
        logic border_on;
        logic [8:0] r;
`ifdef CHAR_BORDER_EN
        border_on = 1'b1;
`else
        border_on = 1'b0;
`endif
        if (code == 0) r = 9'd0;
        else if (border_on && edge_ != 0) r = ~BG;
        else r = (code == 1) ? FG : BG;
        return r;
    endfunction

    task automatic push(input int kind, input int lat, input logic [9:0] val);
        exp_t e;
        e.due = cyc + lat;
        e.kind = kind;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic at(input int h, input int v);
        int n = 0;
        while (!(mh == h && mv == v) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        if (!(mh == h && mv == v)) begin
            n_vec = n_vec + 1;
            n_miss = n_miss + 1;
            $display("FAIL wait_pos: at %0d/%0d, required %0d/%0d", mh, mv, h, v);
        end
    endtask

    task automatic apply(input vec_t t);
        at(t.h, t.v);
        push(0, 1, 10'(t.re));
        if (t.col >= 0) push(1, 1, 10'(t.col));
        if (t.row >= 0) push(2, 1, 10'(t.row));
        push(3, 2, {1'b0, exp_rgb(t.rgb, t.edge_)});
        if (t.hs >= 0) push(4, 2, 10'(t.hs));
        if (t.vs >= 0) push(5, 2, 10'(t.vs));
    endtask

    initial begin
        // rgb code: 0 black, 1 fgColor, 2 bgColor; edge_ marks border pixels
        // frame 0, centre window rows 8..39, columns 304..335
        vecs[0]  = '{0,   0,  0, -1, -1, 0, 0,  1,  1};
        vecs[1]  = '{655, 0,  0, -1, -1, 0, 0,  1, -1};
        vecs[2]  = '{656, 0,  0, -1, -1, 0, 0,  0, -1};
        vecs[3]  = '{751, 0,  0, -1, -1, 0, 0,  0, -1};
        vecs[4]  = '{752, 0,  0, -1, -1, 0, 0,  1, -1};
        vecs[5]  = '{303, 8,  0, -1, -1, 0, 0, -1, -1};
        vecs[6]  = '{304, 8,  1,  0,  0, 2, 1, -1, -1};
        vecs[7]  = '{311, 8,  1,  1,  0, 1, 1, -1, -1};
        vecs[8]  = '{335, 8,  1,  7,  0, 1, 1, -1, -1};
        vecs[9]  = '{336, 8,  0,  7,  0, 0, 0, -1, -1};
        vecs[10] = '{304, 20, 1,  0,  3, 1, 1, -1, -1};
        vecs[11] = '{312, 20, 1,  2,  3, 1, 0, -1, -1};
        vecs[12] = '{316, 20, 1,  3,  3, 2, 0, -1, -1};
        vecs[13] = '{335, 20, 1,  7,  3, 2, 1, -1, -1};
        vecs[14] = '{650, 20, 0,  7,  3, 0, 0,  1, -1};
        // after the mid-frame input change: old window still in force
        vecs[15] = '{320, 39, 1,  4,  7, 1, 1, -1, -1};
        vecs[16] = '{320, 40, 0, -1, -1, 0, 0, -1, -1};
        vecs[17] = '{624, 45, 0, -1, -1, 0, 0, -1, -1};
        vecs[18] = '{0,   51, 0, -1, -1, 0, 0, -1,  1};
        vecs[19] = '{0,   52, 0, -1, -1, 0, 0, -1,  0};
        vecs[20] = '{799, 53, 0, -1, -1, 0, 0, -1,  0};
        vecs[21] = '{0,   54, 0, -1, -1, 0, 0, -1,  1};
        // frame 1, wrapped window rows 44..3, columns 624..15
        vecs[22] = '{0,   0,  1,  4,  1, 1, 0, -1, -1};
        vecs[23] = '{15,  0,  1,  7,  1, 2, 1, -1, -1};
        vecs[24] = '{16,  0,  0,  7,  1, 0, 0, -1, -1};
        vecs[25] = '{320, 0,  0, -1, -1, 0, 0, -1, -1};
        vecs[26] = '{624, 0,  1,  0,  1, 1, 1, -1, -1};
        vecs[27] = '{639, 0,  1,  3,  1, 2, 0, -1, -1};
        vecs[28] = '{5,   3,  1,  5,  1, 2, 0, -1, -1};
        vecs[29] = '{5,   4,  0, -1, -1, 0, 0, -1, -1};

        reset = 1'b1;
        posVerStart = 9'd8;
        posVerEnd   = 9'd39;
        posHorStart = 10'd304;
        posHorEnd   = 10'd335;
        fgColor = FG;
        bgColor = BG;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of the sync pulse, then hold it for three cycles.
        at(700, 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(0, 1, 10'd0);
            push(1, 1, 10'd0);
            push(2, 1, 10'd0);
            push(3, 1, 10'd0);
            push(4, 1, 10'd1);
            push(5, 1, 10'd1);
            @(negedge clk);
        end
        reset = 1'b0;

        for (int i = 0; i < 15; i++) apply(vecs[i]);
        at(100, 30);
        posVerStart = 9'd44;
        posVerEnd   = 9'd3;
        posHorStart = 10'd624;
        posHorEnd   = 10'd15;
        for (int i = 15; i < 30; i++) apply(vecs[i]);

        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            n_vec = n_vec + 1;
            n_miss = n_miss + 1;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog: run exceeded 90000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
